// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants (also used by the ALU), writeback
// fault codes, the memory-access stage state encoding and opcode helpers.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_LDB = 4'd10;
  localparam logic [3:0] OP_LDW = 4'd11;
  localparam logic [3:0] OP_STB = 4'd12;
  localparam logic [3:0] OP_STW = 4'd13;
  localparam logic [3:0] OP_MOV = 4'd14;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_LDW) || (op == OP_STB) || (op == OP_STW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_STB) || (op == OP_STW);
  endfunction

  function automatic logic is_byte_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of the three handshakes around the memory-access stage:
//   in_*  : ALU result/op (valid/ready, stage is the consumer)
//   mem_* : data-memory request (req/ack, stage is the requester)
//   wb_*  : writeback payload (valid/ready, stage is the producer)
// master = the stage's view, slave = the surrounding pipeline/memory view.
interface mem_access_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_fault;

  modport master (
    input  in_valid, in_op, in_result, in_store_data, in_rd,
           mem_ack, mem_rdata, wb_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_we, wb_rd, wb_data, wb_fault
  );

  modport slave (
    output in_valid, in_op, in_result, in_store_data, in_rd,
           mem_ack, mem_rdata, wb_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_we, wb_rd, wb_data, wb_fault
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the memory stage.
//   op, addr_lo      : opcode and byte offset of the access
//   store_data       : rt value; be/wdata are the byte enables and bus data
//   rdata            : memory read word; load_data is the register value
// Byte ops use one lane selected by addr_lo; word ops use all four.
module mem_lane_align
  import cpu_pkg::*;
#(
  parameter bit LDB_SIGNED = 1'b0
) (
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] lane_byte;

  always_comb begin
    be        = is_byte_op(op) ? (4'b0001 << addr_lo) : 4'b1111;
    // A byte store drives its byte on every lane; be picks the real one.
    wdata     = is_byte_op(op) ? {4{store_data[7:0]}} : store_data;
    lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    load_data = rdata;
    if (op == OP_LDB) begin
      load_data = {{24{LDB_SIGNED & lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: loads/stores go to data memory over req/ack, all other
// ops pass the ALU result through; the result is offered to writeback.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : in_* / mem_* / wb_* handshakes (master modport)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | nothing held, ready for a new op
//   MEM     | memory request outstanding, waiting for mem_ack
//   HOLD    | writeback payload presented, waiting for wb_ready
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter bit          LDB_SIGNED  = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_stage_if.master bus
);

  localparam int unsigned    CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [1:0]         lane_q, lane_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               wb_we_q, wb_we_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  fault_e             wb_fault_q, wb_fault_d;

  logic               ready;
  logic               accept;
  logic [3:0]         al_op;
  logic [1:0]         al_lane;
  logic [3:0]         al_be;
  logic [31:0]        al_wdata;
  logic [31:0]        al_load;

  // The aligner serves the incoming op at accept and the captured op in MEM;
  // accept never happens in MEM, so one instance covers both uses.
  assign al_op   = (state_q == ST_MEM) ? op_q   : bus.in_op;
  assign al_lane = (state_q == ST_MEM) ? lane_q : bus.in_result[1:0];

  mem_lane_align #(.LDB_SIGNED(LDB_SIGNED)) u_align (
    .op         (al_op),
    .addr_lo    (al_lane),
    .store_data (bus.in_store_data),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_fault_d  = wb_fault_q;

    ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.wb_ready);
    accept = bus.in_valid && ready;

    case (state_q)
      ST_MEM: begin
        // An ack in the terminal-count cycle still completes the access.
        if (bus.mem_ack) begin
          state_d    = ST_HOLD;
          wb_fault_d = FAULT_NONE;
          wb_we_d    = !is_store_op(op_q);
          wb_data_d  = is_store_op(op_q) ? 32'h0 : al_load;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d    = ST_HOLD;
          wb_fault_d = FAULT_TIMEOUT;
          wb_we_d    = 1'b0;
          wb_data_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if ((state_q == ST_HOLD) && bus.wb_ready) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          wb_rd_d = bus.in_rd;
          op_d    = bus.in_op;
          lane_d  = bus.in_result[1:0];
          cnt_d   = '0;
          if (!is_mem_op(bus.in_op)) begin
            state_d    = ST_HOLD;
            wb_we_d    = 1'b1;
            wb_data_d  = bus.in_result;
            wb_fault_d = FAULT_NONE;
          end else if (!is_byte_op(bus.in_op) && (bus.in_result[1:0] != 2'b00)) begin
            state_d    = ST_HOLD;
            wb_we_d    = 1'b0;
            wb_data_d  = 32'h0;
            wb_fault_d = FAULT_MISALIGN;
          end else begin
            state_d     = ST_MEM;
            mem_we_d    = is_store_op(bus.in_op);
            mem_addr_d  = {bus.in_result[31:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= 4'h0;
      lane_q      <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'h0;
      wb_data_q   <= 32'h0;
      wb_fault_q  <= FAULT_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_req   = (state_q == ST_MEM);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = (state_q == ST_HOLD);
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_fault  = wb_fault_q;

endmodule
